instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
// - Fetch stage feeding CPUControl. Owns the 64-bit PC and issues requests to instruction memory.
// - Holds the fetched 32-bit instruction stable for decode/execute until the downstream logic acknowledges it.
// - On acknowledge, computes the next PC from BrTaken/UncondBr and the branch fields of the held instruction.
// - Handles a variable-latency instruction memory with a request/ready handshake and a fetch timeout.
// PARAMETERS
// ADDR_W       64        PC / address width in bits
// RESET_PC     64'h0     PC value loaded on reset
// TIMEOUT      16        max cycles in FETCH waiting for imem_ready before fetch_err
// PORTS
// clk          in   1       clock; all state updates on posedge
// reset        in   1       synchronous, active-low reset
// imem_req     out  1       fetch request to instruction memory
// imem_addr    out  ADDR_W  fetch address (= PC)
// imem_ready   in   1       imem_rdata valid this cycle
// imem_rdata   in   32      instruction word from memory
// instr        out  32      held instruction (OPCode to CPUControl)
// instr_valid  out  1       instr holds a valid instruction
// pc           out  ADDR_W  address of held/pending instruction
// instr_ack    in   1       downstream finished with instr; advance PC
// BrTaken      in   1       from CPUControl; sampled only when instr_ack=1
// UncondBr     in   1       from CPUControl; 1 selects BrAddr26, 0 selects CondAddr19
// fetch_err    out  1       sticky: imem did not respond within TIMEOUT
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - pc=RESET_PC, state=FETCH, instr=32'h0, instr_valid=0, fetch_err=0, wait_cnt=0.
//   - Any in-flight fetch is abandoned; imem_ready seen in a reset cycle is ignored.
// - State FETCH:
//   - imem_req=1, imem_addr=pc, instr_valid=0.
//   - If imem_ready=1: instr<=imem_rdata, wait_cnt<=0, go to VALID.
//   - Else wait_cnt++. When wait_cnt reaches TIMEOUT-1 with no ready: fetch_err<=1, go to ERROR.
// - State VALID:
//   - imem_req=0, instr_valid=1; instr and pc stable.
//   - instr_ack=0: hold (stall). No limit on stall length.
//   - instr_ack=1: pc<=next_pc, go to FETCH.
//   - Minimum one VALID cycle; ack is ignored outside VALID.
// - State ERROR:
//   - imem_req=0, instr_valid=0, fetch_err=1.
//   - Only reset exits this state.
// - next_pc computation:
//   - BrTaken=0: pc+4.
//   - BrTaken=1, UncondBr=1: pc + (sext(instr[25:0])<<2).
//   - BrTaken=1, UncondBr=0: pc + (sext(instr[23:5])<<2).
//   - All sums are ADDR_W bits, modulo 2^ADDR_W (wrap-around is silent, no flag).
//   - BrTaken/UncondBr equal to X/Z when ack=1 and the decode is non-branch: treat as 0 (use ===1'b1 compare).
// - Latency:
//   - Zero-wait memory (ready in the first FETCH cycle) gives instr_valid 1 cycle after the request.
//   - Best case: one instruction per 2 cycles.
// - Outputs are registered, except imem_req/imem_addr: combinational from state/pc.
// TESTING
// - Reset held low 3 cycles, imem_ready=1 -> imem_req=1 and imem_addr=0 first cycle after release; instr_valid=0 during reset.
// - Straight-line, 0-wait memory, ack on every VALID cycle, BrTaken=0 -> pc sequence 0,4,8,C; instr matches memory contents.
// - B at pc=0x10, instr[25:0]=26'h3FFFFFF, BrTaken=1, UncondBr=1 -> next imem_addr=0x0C.
// - CBZ at pc=0x20, instr[23:5]=19'd5, UncondBr=0:
//   - BrTaken=1 -> next pc=0x34.
//   - BrTaken=0 -> next pc=0x24.
// - 3-cycle imem latency, then ack held low 4 cycles -> instr_valid=1 and instr/pc unchanged for all stall cycles; pc advances only on ack.
// - imem_ready never asserted -> fetch_err=1 after TIMEOUT=16 FETCH cycles, imem_req=0 afterwards; reset mid-ERROR and mid-FETCH -> pc=RESET_PC, fetch_err=0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit bus: imem handshake, held instruction, branch control
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 64
) ();
  // instruction memory side
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  // decode/execute side
  logic [31:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              instr_ack;
  logic              BrTaken;
  logic              UncondBr;
  logic              fetch_err;

  // master: the fetch unit itself
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, fetch_err,
    input  imem_ready, imem_rdata, instr_ack, BrTaken, UncondBr
  );

  // slave: memory plus downstream control logic
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, fetch_err,
    output imem_ready, imem_rdata, instr_ack, BrTaken, UncondBr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, imem fetch with timeout, held instruction, branch next-PC
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  // Counter must hold values 0..TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              br_taken;
  logic              br_uncond;
  logic [ADDR_W-1:0] off_uncond;
  logic [ADDR_W-1:0] off_cond;
  logic [ADDR_W-1:0] next_pc;

  // Branch target selection from the held instruction; X/Z control reads as not-taken.
  always_comb begin
    br_taken   = (bus.BrTaken === 1'b1);
    br_uncond  = (bus.UncondBr === 1'b1);
    off_uncond = {{(ADDR_W-28){instr_q[25]}}, instr_q[25:0], 2'b00};
    off_cond   = {{(ADDR_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};
    next_pc    = pc_q + ADDR_W'(4);
    if (br_taken) begin
      next_pc = br_uncond ? (pc_q + off_uncond) : (pc_q + off_cond);
    end
  end

  // Next-state logic for the fetch / hold / error sequence.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end else if (cnt_q == CNT_MAX) begin
          // memory never answered: park until reset
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VALID: begin
        // instr/pc stay put for as long as downstream stalls
        if (bus.instr_ack) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_ERROR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers; reset abandons any in-flight fetch and ignores imem_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request and address follow state/pc directly so a fetch starts the cycle FETCH is entered.
  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized and directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [63:0] exp_pc;

  instruction_fetch_unit_if #(.ADDR_W(64)) bus ();

  instruction_fetch_unit #(
    .ADDR_W(64),
    .RESET_PC(64'h0),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference next-PC: plain signed arithmetic on the branch immediates.
  function automatic logic [63:0] model_next(input logic [63:0] cur, input logic [31:0] w,
                                             input logic br, input logic unc);
    longint off;
    if (!br)     off = 4;
    else if (unc) off = longint'($signed(w[25:0])) * 4;
    else          off = longint'($signed(w[23:5])) * 4;
    return cur + 64'(off);
  endfunction

  task automatic do_reset(input int cycles);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    bus.instr_ack  = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      chk("rst_valid", bus.instr_valid, 1'b0);
      chk("rst_err", bus.fetch_err, 1'b0);
      chk("rst_pc", bus.pc, 64'h0);
    end
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    bus.instr_ack  = 1'b0;
    exp_pc = 64'h0;
    chk("rel_req", bus.imem_req, 1'b1);
    chk("rel_addr", bus.imem_addr, 64'h0);
  endtask

  // One complete fetch/hold/ack transaction against the model.
  task automatic do_fetch(input int lat, input logic [31:0] word, input int stall,
                          input logic br, input logic unc);
    chk("f_req", bus.imem_req, 1'b1);
    chk("f_addr", bus.imem_addr, exp_pc);
    chk("f_valid", bus.instr_valid, 1'b0);
    for (int i = 0; i < lat; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      bus.instr_ack  = 1'($urandom_range(0, 1));
      step();
      chk("w_req", bus.imem_req, 1'b1);
      chk("w_valid", bus.instr_valid, 1'b0);
      chk("w_addr", bus.imem_addr, exp_pc);
    end
    bus.instr_ack  = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    chk("v_valid", bus.instr_valid, 1'b1);
    chk("v_instr", bus.instr, word);
    chk("v_pc", bus.pc, exp_pc);
    chk("v_req", bus.imem_req, 1'b0);
    for (int i = 0; i < stall; i++) begin
      bus.instr_ack = 1'b0;
      bus.BrTaken   = 1'($urandom_range(0, 1));
      bus.UncondBr  = 1'($urandom_range(0, 1));
      step();
      chk("s_valid", bus.instr_valid, 1'b1);
      chk("s_instr", bus.instr, word);
      chk("s_pc", bus.pc, exp_pc);
    end
    bus.instr_ack = 1'b1;
    bus.BrTaken   = br;
    bus.UncondBr  = unc;
    step();
    bus.instr_ack = 1'b0;
    bus.BrTaken   = 1'b0;
    bus.UncondBr  = 1'b0;
    exp_pc = model_next(exp_pc, word, br, unc);
  endtask

  initial begin
    logic [31:0] mem [4];
    logic [31:0] w;
    mem[0] = 32'h8B020020;
    mem[1] = 32'hCB030041;
    mem[2] = 32'hF8400062;
    mem[3] = 32'hAA0400A3;
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ack  = 1'b0;
    bus.BrTaken    = 1'b0;
    bus.UncondBr   = 1'b0;

    // reset held 3 cycles with imem_ready high
    do_reset(3);

    // straight line, zero-wait, immediate ack
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", bus.imem_addr, 64'(i * 4));
      do_fetch(0, mem[i], 0, 1'b0, 1'b0);
    end
    chk("seq_end", bus.imem_addr, 64'h10);

    // B with offset -1 word at 0x10
    do_fetch(0, 32'h17FFFFFF, 0, 1'b1, 1'b1);
    chk("b_back", bus.imem_addr, 64'h0C);

    // B +5 words from 0x0C lands on 0x20
    do_fetch(1, 32'h14000005, 0, 1'b1, 1'b1);
    chk("b_fwd", bus.imem_addr, 64'h20);

    // CBZ imm19=5 taken
    do_fetch(0, 32'hB40000A0, 1, 1'b1, 1'b0);
    chk("cbz_taken", bus.imem_addr, 64'h34);

    // back to 0x20 then CBZ not taken
    do_fetch(0, 32'h17FFFFFB, 0, 1'b1, 1'b1);
    chk("b_ret", bus.imem_addr, 64'h20);
    do_fetch(0, 32'hB40000A0, 0, 1'b0, 1'b0);
    chk("cbz_not", bus.imem_addr, 64'h24);

    // 3-cycle latency and 4-cycle stall
    do_fetch(3, 32'h91000421, 4, 1'b0, 1'b0);
    chk("stall_adv", bus.imem_addr, 64'h28);

    // randomized transactions
    for (int i = 0; i < 25; i++) begin
      w = $urandom;
      do_fetch($urandom_range(0, 5), w, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("rnd_addr", bus.imem_addr, exp_pc);

    // timeout: memory never answers
    do_reset(1);
    for (int k = 0; k < 16; k++) begin
      chk("to_req", bus.imem_req, 1'b1);
      chk("to_err_lo", bus.fetch_err, 1'b0);
      bus.instr_ack = 1'($urandom_range(0, 1));
      step();
    end
    chk("to_err", bus.fetch_err, 1'b1);
    chk("to_req_off", bus.imem_req, 1'b0);
    chk("to_valid", bus.instr_valid, 1'b0);
    bus.imem_ready = 1'b1;
    bus.instr_ack  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("err_stick", bus.fetch_err, 1'b1);
      chk("err_req", bus.imem_req, 1'b0);
    end

    // reset mid-ERROR
    do_reset(1);
    chk("err_clr", bus.fetch_err, 1'b0);

    // backward branch from 0 wraps to top of address space, then +4 wraps to 0
    do_fetch(0, 32'h17FFFFFF, 0, 1'b1, 1'b1);
    chk("wrap_hi", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(2, 32'hD503201F, 0, 1'b0, 1'b0);
    chk("wrap_lo", bus.imem_addr, 64'h0);
    do_fetch(0, 32'hD503201F, 0, 1'b0, 1'b0);
    chk("pre_rst", bus.imem_addr, 64'h4);

    // reset mid-FETCH
    for (int k = 0; k < 5; k++) begin
      bus.imem_ready = 1'b0;
      step();
    end
    do_reset(2);
    chk("mf_pc", bus.pc, 64'h0);
    do_fetch(0, 32'h12345678, 0, 1'b0, 1'b0);
    chk("mf_next", bus.imem_addr, 64'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
